a_fetch_unit: RTL

Fetch stage for matrix A, directly downstream of the A address generator's address FIFO. It pops row addresses, issues 256-bit reads on the memory read port, and keeps in-flight reads bounded by a credit count. It assembles every ARRAY_HEIGHT returned lines into one tile, which it presents to the systolic-array row feeders over a valid/ready handshake.

---
 rtl/matrix_pkg.sv | 11 +
 rtl/a_line_fifo.sv | 47 ++++
 rtl/a_fetch_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// Shared widths, line/address types and FSM encodings for the matrix operand fetch path.
package matrix_pkg;
  localparam int BUS_WIDTH  = 256;
  localparam int ADDR_WIDTH = 16;

  typedef logic [BUS_WIDTH-1:0]  line_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic {IDLE, REQ} issue_state_t;
  typedef enum logic {COLLECT, PRESENT} asm_state_t;
endpackage

// File: rtl/a_line_fifo.sv
// Line buffer: synchronous first-word-fall-through FIFO, head valid one cycle after push.
// Push is ignored when full and pop when empty; the caller's credits keep it from filling.
module a_line_fifo
  import matrix_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  push,
  input  line_t push_dat,
  input  logic  pop,
  output line_t pop_dat,
  output logic  empty,
  output logic  full
);
  localparam int PW = $clog2(DEPTH);

  line_t       mem [DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign pop_dat = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[PW-1:0]] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/a_fetch_unit.sv
// Matrix A fetch: pops row addresses, issues credit-bounded reads (req 1 cycle after FIFO non-empty),
// packs ARRAY_HEIGHT lines per tile (line->slot 1 cycle); issue stalls when credits run out or a tile waits.
module a_fetch_unit
  import matrix_pkg::*;
#(
  parameter int ARRAY_HEIGHT = 4,
  parameter int LINE_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_WIDTH-1:0]             a_fifo_addr,
  input  logic                              a_fifo_empty,
  output logic                              a_fifo_pop,
  output logic                              mem_rd_req,
  output logic [ADDR_WIDTH-1:0]             mem_rd_addr,
  input  logic                              mem_rd_gnt,
  input  logic                              mem_rd_valid,
  input  logic [BUS_WIDTH-1:0]              mem_rd_data,
  output logic                              a_tile_valid,
  output logic [BUS_WIDTH*ARRAY_HEIGHT-1:0] a_tile_data,
  input  logic                              a_tile_ready,
  output logic                              a_busy,
  output logic                              a_err
);
  localparam int CW = $clog2(LINE_DEPTH) + 1;
  localparam int RW = $clog2(ARRAY_HEIGHT);

  issue_state_t issue_state;
  asm_state_t   asm_state;
  logic [CW-1:0] credits;
  logic [CW-1:0] outstanding;
  logic [RW-1:0] row_cnt;
  logic [ARRAY_HEIGHT-1:0][BUS_WIDTH-1:0] tile_q;

  logic  gnt_acc;
  logic  beat_ok;
  logic  line_push;
  logic  line_pop;
  logic  line_empty;
  logic  line_full;
  line_t line_dat;

  assign gnt_acc    = mem_rd_req && mem_rd_gnt;
  assign a_fifo_pop = !reset && !a_fifo_empty && (credits != '0) &&
                      ((issue_state == IDLE) || gnt_acc);

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_state <= IDLE;
      mem_rd_req  <= 1'b0;
      mem_rd_addr <= '0;
    end else begin
      case (issue_state)
        IDLE: begin
          if (a_fifo_pop) begin
            mem_rd_addr <= a_fifo_addr;
            mem_rd_req  <= 1'b1;
            issue_state <= REQ;
          end
        end
        REQ: begin
          // Request and address hold until granted; a grant may chain straight into the next address.
          if (gnt_acc) begin
            if (a_fifo_pop) begin
              mem_rd_addr <= a_fifo_addr;
            end else begin
              mem_rd_req  <= 1'b0;
              issue_state <= IDLE;
            end
          end
        end
        default: issue_state <= IDLE;
      endcase
    end
  end

  // A beat with nothing outstanding is dropped and flagged rather than counted.
  assign beat_ok   = mem_rd_valid && (outstanding != '0);
  assign line_push = beat_ok && !line_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      credits     <= CW'(LINE_DEPTH);
      outstanding <= '0;
      a_err       <= 1'b0;
    end else begin
      case ({a_fifo_pop, line_pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
      case ({gnt_acc, beat_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (mem_rd_valid && (outstanding == '0)) begin
        a_err <= 1'b1;
      end
    end
  end

  a_line_fifo #(
    .DEPTH(LINE_DEPTH)
  ) u_line_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (line_push),
    .push_dat (mem_rd_data),
    .pop      (line_pop),
    .pop_dat  (line_dat),
    .empty    (line_empty),
    .full     (line_full)
  );

  // The consuming handshake frees the tile, so slot 0 may refill on that same edge.
  assign line_pop = !line_empty && ((asm_state == COLLECT) || a_tile_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_state    <= COLLECT;
      row_cnt      <= '0;
      tile_q       <= '0;
      a_tile_valid <= 1'b0;
    end else begin
      if ((asm_state == PRESENT) && a_tile_ready) begin
        asm_state    <= COLLECT;
        a_tile_valid <= 1'b0;
      end
      if (line_pop) begin
        tile_q[row_cnt] <= line_dat;
        if (row_cnt == RW'(ARRAY_HEIGHT - 1)) begin
          row_cnt      <= '0;
          asm_state    <= PRESENT;
          a_tile_valid <= 1'b1;
        end else begin
          row_cnt <= row_cnt + RW'(1);
        end
      end
    end
  end

  assign a_tile_data = tile_q;
  assign a_busy      = (credits != CW'(LINE_DEPTH)) || (row_cnt != '0) || a_tile_valid;
endmodule
